// File: rtl/pipe_pkg.sv
// Shared types for the pipeline register bank and hazard controller.
package pipe_pkg;

  // E-stage operand source select
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  localparam int DEF_REG_W = 4;

  // Per-stage hazard metadata at the default register-address width.
  // The top re-declares the same layout at its own REG_W.
  typedef struct packed {
    logic [DEF_REG_W-1:0] ra1;
    logic [DEF_REG_W-1:0] ra2;
    logic                 use1;
    logic                 use2;
    logic [DEF_REG_W-1:0] wa;
    logic                 regwrite;
    logic                 memtoreg;
  } stage_meta_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline register. clr inserts a bubble (all zeros) and wins over en.
// en=0 holds the current contents.
module pipe_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  // Stage register: reset, then bubble, then load, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q_q <= '0;
    else if (clr) q_q <= '0;
    else if (en)  q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// D/E/M/W pipeline register bank with load-use / RAW stall, branch flush,
// M/W operand forwarding and saturating stall/flush event counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = 32,
  parameter int REG_W     = 4,
  parameter int PC_REG    = 15,
  parameter int FWD_EN    = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 f_valid,
  input  logic [PAYLOAD_W-1:0] f_payload,
  input  logic [REG_W-1:0]     id_ra1,
  input  logic [REG_W-1:0]     id_ra2,
  input  logic                 id_use1,
  input  logic                 id_use2,
  input  logic [REG_W-1:0]     id_wa,
  input  logic                 id_regwrite,
  input  logic                 id_memtoreg,
  input  logic [PAYLOAD_W-1:0] id_payload,
  input  logic [PAYLOAD_W-1:0] ex_payload,
  input  logic [PAYLOAD_W-1:0] mem_payload,
  input  logic                 ex_branch,
  output logic                 d_valid,
  output logic                 e_valid,
  output logic                 m_valid,
  output logic                 w_valid,
  output logic [PAYLOAD_W-1:0] d_payload,
  output logic [PAYLOAD_W-1:0] e_payload,
  output logic [PAYLOAD_W-1:0] m_payload,
  output logic [PAYLOAD_W-1:0] w_payload,
  output logic [REG_W-1:0]     w_wa,
  output logic                 w_regwrite,
  output logic [1:0]           fwd_a,
  output logic [1:0]           fwd_b,
  output logic                 stall_f,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  typedef struct packed {
    logic [REG_W-1:0] ra1;
    logic [REG_W-1:0] ra2;
    logic             use1;
    logic             use2;
    logic [REG_W-1:0] wa;
    logic             regwrite;
    logic             memtoreg;
  } meta_t;

  localparam int               MW = $bits(meta_t);
  localparam logic [REG_W-1:0] PC = REG_W'(PC_REG);

  meta_t id_meta, e_meta, m_meta, w_meta;
  logic [PAYLOAD_W:0]    d_d, d_q;
  logic [PAYLOAD_W+MW:0] e_d, e_q, m_d, m_q, w_d, w_q;
  logic raw_e, raw_m, raw_w, stall, flush;
  fwd_sel_t fa, fb;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic unused_meta;

  // Writes to the PC index are not register-file writes for hazard purposes
  function automatic logic effw(input logic v, input meta_t x);
    return v & x.regwrite & (x.wa != PC);
  endfunction

  function automatic logic hit(input logic v, input meta_t x,
                               input logic [REG_W-1:0] r, input logic u);
    return u & (r != PC) & effw(v, x) & (x.wa == r);
  endfunction

  assign id_meta = '{ra1: id_ra1, ra2: id_ra2, use1: id_use1, use2: id_use2,
                     wa: id_wa, regwrite: id_regwrite, memtoreg: id_memtoreg};

  assign d_d = {f_valid, f_payload};
  assign e_d = {d_valid, id_meta, id_payload};
  assign m_d = {e_valid, e_meta, ex_payload};
  assign w_d = {m_valid, m_meta, mem_payload};

  assign {d_valid, d_payload}         = d_q;
  assign {e_valid, e_meta, e_payload} = e_q;
  assign {m_valid, m_meta, m_payload} = m_q;
  assign {w_valid, w_meta, w_payload} = w_q;

  // Source fields of M/W are carried for visibility only
  assign unused_meta = ^{m_meta, w_meta};

  pipe_stage_reg #(.W(PAYLOAD_W+1)) u_d (
    .clk(clk), .rst_n(reset), .en(~stall_f), .clr(flush), .d_i(d_d), .q_o(d_q));
  pipe_stage_reg #(.W(PAYLOAD_W+MW+1)) u_e (
    .clk(clk), .rst_n(reset), .en(1'b1), .clr(flush | stall_f), .d_i(e_d), .q_o(e_q));
  pipe_stage_reg #(.W(PAYLOAD_W+MW+1)) u_m (
    .clk(clk), .rst_n(reset), .en(1'b1), .clr(1'b0), .d_i(m_d), .q_o(m_q));
  pipe_stage_reg #(.W(PAYLOAD_W+MW+1)) u_w (
    .clk(clk), .rst_n(reset), .en(1'b1), .clr(1'b0), .d_i(w_d), .q_o(w_q));

  // Hazard detection: D sources against in-flight writers; flush beats stall
  always_comb begin
    raw_e   = hit(e_valid, e_meta, id_ra1, id_use1) | hit(e_valid, e_meta, id_ra2, id_use2);
    raw_m   = hit(m_valid, m_meta, id_ra1, id_use1) | hit(m_valid, m_meta, id_ra2, id_use2);
    raw_w   = hit(w_valid, w_meta, id_ra1, id_use1) | hit(w_valid, w_meta, id_ra2, id_use2);
    stall   = d_valid & ((FWD_EN != 0) ? (raw_e & e_meta.memtoreg) : (raw_e | raw_m | raw_w));
    flush   = ex_branch & e_valid;
    stall_f = stall & ~flush;
  end

  // Operand forwarding for the instruction in E; M is newer so it wins over W
  always_comb begin
    fa = FWD_RF;
    fb = FWD_RF;
    if (FWD_EN != 0) begin
      if (hit(m_valid, m_meta, e_meta.ra1, e_valid & e_meta.use1))      fa = FWD_M;
      else if (hit(w_valid, w_meta, e_meta.ra1, e_valid & e_meta.use1)) fa = FWD_W;
      if (hit(m_valid, m_meta, e_meta.ra2, e_valid & e_meta.use2))      fb = FWD_M;
      else if (hit(w_valid, w_meta, e_meta.ra2, e_valid & e_meta.use2)) fb = FWD_W;
    end
  end

  assign fwd_a      = fa;
  assign fwd_b      = fb;
  assign w_wa       = w_meta.wa;
  assign w_regwrite = w_valid & w_meta.regwrite;

  // Saturating event counters for effective stalls and flushes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush && flush_cnt_q != '1)   flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: a forwarding instance (FWD_EN=1), a stall-only instance
// (FWD_EN=0) and a stall-only instance with 2-bit counters share one stimulus.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        f_valid, id_use1, id_use2, id_regwrite, id_memtoreg, ex_branch;
  logic [31:0] f_payload, id_payload, ex_payload, mem_payload;
  logic [3:0]  id_ra1, id_ra2, id_wa;

  logic        a_dv, a_ev, a_mv, a_wv, a_wrw, a_sf;
  logic [31:0] a_dp, a_ep, a_mp, a_wp;
  logic [3:0]  a_wa;
  logic [1:0]  a_fa, a_fb;
  logic [15:0] a_sc, a_fc;

  logic        b_dv, b_ev, b_mv, b_wv, b_wrw, b_sf;
  logic [31:0] b_dp, b_ep, b_mp, b_wp;
  logic [3:0]  b_wa;
  logic [1:0]  b_fa, b_fb;
  logic [15:0] b_sc, b_fc;

  logic        c_dv, c_ev, c_mv, c_wv, c_wrw, c_sf;
  logic [31:0] c_dp, c_ep, c_mp, c_wp;
  logic [3:0]  c_wa;
  logic [1:0]  c_fa, c_fb;
  logic [1:0]  c_sc, c_fc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FWD_EN(1), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .f_valid(f_valid), .f_payload(f_payload),
    .id_ra1(id_ra1), .id_ra2(id_ra2), .id_use1(id_use1), .id_use2(id_use2),
    .id_wa(id_wa), .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg),
    .id_payload(id_payload), .ex_payload(ex_payload), .mem_payload(mem_payload),
    .ex_branch(ex_branch),
    .d_valid(a_dv), .e_valid(a_ev), .m_valid(a_mv), .w_valid(a_wv),
    .d_payload(a_dp), .e_payload(a_ep), .m_payload(a_mp), .w_payload(a_wp),
    .w_wa(a_wa), .w_regwrite(a_wrw), .fwd_a(a_fa), .fwd_b(a_fb),
    .stall_f(a_sf), .stall_cnt(a_sc), .flush_cnt(a_fc));

  pipe_hazard_ctrl #(.FWD_EN(0), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .f_valid(f_valid), .f_payload(f_payload),
    .id_ra1(id_ra1), .id_ra2(id_ra2), .id_use1(id_use1), .id_use2(id_use2),
    .id_wa(id_wa), .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg),
    .id_payload(id_payload), .ex_payload(ex_payload), .mem_payload(mem_payload),
    .ex_branch(ex_branch),
    .d_valid(b_dv), .e_valid(b_ev), .m_valid(b_mv), .w_valid(b_wv),
    .d_payload(b_dp), .e_payload(b_ep), .m_payload(b_mp), .w_payload(b_wp),
    .w_wa(b_wa), .w_regwrite(b_wrw), .fwd_a(b_fa), .fwd_b(b_fb),
    .stall_f(b_sf), .stall_cnt(b_sc), .flush_cnt(b_fc));

  pipe_hazard_ctrl #(.FWD_EN(0), .CNT_W(2)) us (
    .clk(clk), .reset(reset), .f_valid(f_valid), .f_payload(f_payload),
    .id_ra1(id_ra1), .id_ra2(id_ra2), .id_use1(id_use1), .id_use2(id_use2),
    .id_wa(id_wa), .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg),
    .id_payload(id_payload), .ex_payload(ex_payload), .mem_payload(mem_payload),
    .ex_branch(ex_branch),
    .d_valid(c_dv), .e_valid(c_ev), .m_valid(c_mv), .w_valid(c_wv),
    .d_payload(c_dp), .e_payload(c_ep), .m_payload(c_mp), .w_payload(c_wp),
    .w_wa(c_wa), .w_regwrite(c_wrw), .fwd_a(c_fa), .fwd_b(c_fb),
    .stall_f(c_sf), .stall_cnt(c_sc), .flush_cnt(c_fc));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    f_valid = 0; f_payload = '0;
    id_ra1 = '0; id_ra2 = '0; id_use1 = 0; id_use2 = 0;
    id_wa = '0; id_regwrite = 0; id_memtoreg = 0;
    id_payload = '0; ex_payload = '0; mem_payload = '0; ex_branch = 0;
  endtask

  task automatic dec(input logic [3:0] r1, input logic u1, input logic [3:0] r2, input logic u2,
                     input logic [3:0] wa, input logic rw, input logic mr);
    id_ra1 = r1; id_use1 = u1; id_ra2 = r2; id_use2 = u2;
    id_wa = wa; id_regwrite = rw; id_memtoreg = mr;
  endtask

  task automatic fetch(input logic v, input logic [31:0] p);
    f_valid = v; f_payload = p;
  endtask

  task automatic do_reset();
    idle();
    tick();
    reset = 0;
    #2;
    reset = 1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    // reset held with random inputs
    idle();
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      f_valid = 1'($urandom); f_payload = $urandom;
      id_ra1 = 4'($urandom); id_ra2 = 4'($urandom); id_wa = 4'($urandom);
      id_use1 = 1'($urandom); id_use2 = 1'($urandom);
      id_regwrite = 1'($urandom); id_memtoreg = 1'($urandom);
      id_payload = $urandom; ex_payload = $urandom; mem_payload = $urandom;
      ex_branch = 1'($urandom);
      tick();
    end
    chk("rst_valid", {a_dv, a_ev, a_mv, a_wv}, 4'b0000);
    chk("rst_fwd", {a_fa, a_fb}, 4'b0000);
    chk("rst_stall", {a_sf, b_sf, c_sf}, 3'b000);
    chk("rst_cnt", {a_sc, a_fc}, 32'h0);
    chk("rst_wrw", a_wrw, 1'b0);
    chk("rst_pay", a_wp | a_mp | a_ep | a_dp, 32'h0);
    idle();
    reset = 1;

    // ADD R1 ; SUB R1,R1,R3 ; AND R15,R7,R1 ; ORR R6,R1,R15
    tick(); fetch(1, 32'hA0D0_0001);
    tick(); dec(0, 0, 0, 0, 1, 1, 0); id_payload = 32'h1111_0001; fetch(1, 32'h5B00_0002);
    #1 chk("fw_dpay", a_dp, 32'hA0D0_0001);
    tick(); dec(1, 1, 3, 1, 1, 1, 0); ex_payload = 32'h2222_0002; fetch(1, 32'hA4D0_0003);
    #1 chk("fw_nostall", a_sf, 1'b0);
    chk("fw_epay", a_ep, 32'h1111_0001);
    tick(); dec(7, 1, 1, 1, 15, 1, 0); mem_payload = 32'h3333_0003; fetch(1, 32'h0880_0004);
    #1 chk("fw_from_m", {a_fa, a_fb}, 4'b1000);
    chk("fw_mpay", a_mp, 32'h2222_0002);
    tick(); dec(1, 1, 15, 1, 6, 1, 0); fetch(0, 32'h0);
    #1 chk("fw_m_over_w", {a_fa, a_fb}, 4'b0010);
    chk("fw_wpay", a_wp, 32'h3333_0003);
    chk("fw_wport", {a_wa, a_wrw}, 5'b0001_1);
    tick(); idle();
    #1 chk("fw_from_w_r15", {a_fa, a_fb}, 4'b0100);

    // LDR R2,[R3] ; ADD R5,R2,R4 -> one load-use stall
    do_reset();
    fetch(1, 32'h1D00_0001);
    tick(); dec(3, 1, 0, 0, 2, 1, 1); fetch(1, 32'hADD0_0002);
    tick(); dec(2, 1, 4, 1, 5, 1, 0); fetch(1, 32'h0E70_0003);
    #1 chk("lu_stall", a_sf, 1'b1);
    tick();
    #1 chk("lu_bubble", {a_dv, a_ev, a_mv}, 3'b101);
    chk("lu_dhold", a_dp, 32'hADD0_0002);
    chk("lu_cnt", a_sc, 16'd1);
    chk("lu_release", a_sf, 1'b0);
    tick(); idle();
    #1 chk("lu_fwd_w", {a_fa, a_fb}, 4'b0100);
    chk("lu_cnt2", {a_ev, a_sc}, 17'h1_0001);
    chk("lu_dnext", a_dp, 32'h0E70_0003);

    // taken branch in E alongside a load-use: flush wins
    do_reset();
    fetch(1, 32'h1D00_0011);
    tick(); dec(0, 0, 0, 0, 2, 1, 1); fetch(1, 32'hADD0_0012);
    tick(); dec(2, 1, 0, 0, 5, 1, 0); ex_branch = 1; fetch(1, 32'hBAD0_0013);
    #1 chk("fl_stallf", a_sf, 1'b0);
    tick(); idle(); ex_branch = 1; fetch(1, 32'h7A60_0014);
    #1 chk("fl_bubbles", {a_dv, a_ev, a_mv}, 3'b001);
    chk("fl_cnts", {a_sc, a_fc}, {16'd0, 16'd1});
    tick(); idle();
    #1 chk("fl_einvalid", {a_dv, a_fc}, {1'b1, 16'd1});
    chk("fl_dpay", a_dp, 32'h7A60_0014);

    // stall-only instances: ADD R1 ; SUB R15,R1 -> 3 stalls, then R15 reader,
    // then another RAW chain to push the 2-bit counter past saturation
    do_reset();
    fetch(1, 32'h0ADD_0001);
    tick(); dec(0, 0, 0, 0, 1, 1, 0); fetch(1, 32'h05B0_0002);
    tick(); dec(1, 1, 0, 0, 15, 1, 0); fetch(1, 32'h0E70_0003);
    #1 chk("nf_stall_e", b_sf, 1'b1);
    tick();
    #1 chk("nf_stall_m", b_sf, 1'b1);
    tick();
    #1 chk("nf_stall_w", b_sf, 1'b1);
    tick();
    #1 chk("nf_clear", b_sf, 1'b0);
    chk("nf_cnt3", {b_sc, 14'd0, c_sc}, {16'd3, 14'd0, 2'd3});
    chk("nf_fwd", {b_fa, b_fb}, 4'b0000);
    tick(); dec(15, 1, 15, 1, 3, 1, 0); fetch(1, 32'h05E0_0004);
    #1 chk("nf_r15", b_sf, 1'b0);
    tick(); dec(3, 1, 0, 0, 0, 0, 0); fetch(1, 32'h0000_0005);
    #1 chk("nf_stall2", b_sf, 1'b1);
    tick();
    tick();
    #1 chk("nf_cnt5", b_sc, 16'd5);
    chk("sat_cnt", c_sc, 2'd3);
    chk("nf_valid", {b_dv, b_ev, b_mv, b_wv}, 4'b1001);

    // async reset in the middle of a cycle
    #2 reset = 0;
    #1 chk("ar_valid", {b_dv, b_ev, b_mv, b_wv}, 4'b0000);
    chk("ar_cnt", {b_sc, b_fc, 14'd0, c_sc}, 48'h0);
    chk("ar_stall", b_sf, 1'b0);
    tick();
    reset = 1;
    dec(0, 0, 0, 0, 4, 1, 0); fetch(1, 32'h0000_0006);
    tick();
    #1 chk("ar_nowrite", {b_wrw, b_wv, a_wrw}, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
